// File: rtl/qspi_rx_shifter_if.sv
// Receive-word stream between the QSPI RX shifter (master) and its consumer (slave).
interface qspi_rx_shifter_if #(
   parameter int DW = 32
);
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/qspi_rx_shifter.sv
// QSPI receive shifter: 1/2/4-lane capture into words of programmable length, MSB/LSB first,
// one-deep holding register. Optional sticky overrun flag enabled by QSPI_RX_OVF_FLAG_EN.
module qspi_rx_shifter #(
   parameter int DW  = 32,
   parameter int CW  = $clog2(DW + 1),
   parameter int WCW = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        mode_i,
   input  logic              msb_first_i,
   input  logic [CW-1:0]     rlen_i,
   input  logic [WCW-1:0]    rwords_i,
   input  logic              sample_i,
   input  logic [3:0]        sdi_i,
   qspi_rx_shifter_if.master rx,
   output logic              busy_o,
   output logic              done_o,
   output logic [CW-1:0]     bit_cnt_o,
   output logic              ovf_o
);
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t         state_reg, state_next;
   logic [1:0]     mode_reg;
   logic           msb_reg;
   logic [CW-1:0]  rlen_reg;
   logic [WCW-1:0] words_reg;
   logic [CW-1:0]  bit_cnt_reg;
   logic [DW-1:0]  sr_reg;
   logic [DW-1:0]  hold_data_reg;
   logic           hold_valid_reg;
   logic           done_reg;

   logic [CW-1:0]  rlen_clamp;
   logic [CW-1:0]  rlen_eff;
   logic [2:0]     lane_cnt;
   logic [CW:0]    cnt_sum;
   logic [DW-1:0]  sr_next;
   logic [DW-1:0]  word_aligned;
   logic           start_ok;
   logic           beat;
   logic           word_end;
   logic           last_word;
   logic           abort_hit;
   logic           accept;
   logic           hold_load;

   // Requested length is clamped to DW, then truncated down to a multiple of the lane count.
   always_comb begin
      rlen_clamp = (rlen_i > CW'(DW)) ? CW'(DW) : rlen_i;
      case (mode_i)
         2'b00:   rlen_eff = rlen_clamp;
         2'b01:   rlen_eff = {rlen_clamp[CW-1:1], 1'b0};
         default: rlen_eff = {rlen_clamp[CW-1:2], 2'b00};
      endcase
   end

   always_comb begin
      case (mode_reg)
         2'b00:   lane_cnt = 3'd1;
         2'b01:   lane_cnt = 3'd2;
         default: lane_cnt = 3'd4;
      endcase
      cnt_sum = {1'b0, bit_cnt_reg} + {{(CW-2){1'b0}}, lane_cnt};
   end

   // Single lane uses sdi_i[1]; within a beat the higher lane index is the more significant bit.
   always_comb begin
      case (mode_reg)
         2'b00:   sr_next = msb_reg ? {sr_reg[DW-2:0], sdi_i[1]}   : {sdi_i[1], sr_reg[DW-1:1]};
         2'b01:   sr_next = msb_reg ? {sr_reg[DW-3:0], sdi_i[1:0]} : {sdi_i[1:0], sr_reg[DW-1:2]};
         default: sr_next = msb_reg ? {sr_reg[DW-5:0], sdi_i}      : {sdi_i, sr_reg[DW-1:4]};
      endcase
      // LSB-first words fill from the top of the register; right-align them at word end.
      word_aligned = msb_reg ? sr_next : (sr_next >> (CW'(DW) - rlen_reg));
   end

   always_comb begin
      state_next = state_reg;
      start_ok   = 1'b0;
      beat       = 1'b0;
      word_end   = 1'b0;
      last_word  = 1'b0;
      abort_hit  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_i && (rwords_i != '0) && (rlen_eff != '0)) begin
               start_ok   = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort_i) begin
               abort_hit  = 1'b1;
               state_next = ST_IDLE;
            end else if (sample_i) begin
               beat = 1'b1;
               if (cnt_sum == {1'b0, rlen_reg}) begin
                  word_end = 1'b1;
                  if (words_reg == WCW'(1)) begin
                     last_word  = 1'b1;
                     state_next = ST_IDLE;
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign accept    = hold_valid_reg & rx.rx_ready;
   assign hold_load = word_end & (~hold_valid_reg | rx.rx_ready);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_reg       <= '0;
         msb_reg        <= 1'b0;
         rlen_reg       <= '0;
         words_reg      <= '0;
         bit_cnt_reg    <= '0;
         sr_reg         <= '0;
         hold_data_reg  <= '0;
         hold_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         done_reg <= last_word | abort_hit;
         if (start_ok) begin
            mode_reg  <= mode_i;
            msb_reg   <= msb_first_i;
            rlen_reg  <= rlen_eff;
            words_reg <= rwords_i;
         end else if (word_end) begin
            words_reg <= words_reg - WCW'(1);
         end
         if (start_ok || word_end || abort_hit) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
         end else if (beat) begin
            sr_reg      <= sr_next;
            bit_cnt_reg <= cnt_sum[CW-1:0];
         end
         // A word finishing into a full, unaccepted holding register is dropped.
         if (hold_load) begin
            hold_data_reg  <= word_aligned;
            hold_valid_reg <= 1'b1;
         end else if (accept) begin
            hold_valid_reg <= 1'b0;
         end
      end
   end

`ifdef QSPI_RX_OVF_FLAG_EN
   logic ovf_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_reg <= 1'b0;
      end else if (start_ok) begin
         ovf_reg <= 1'b0;
      end else if (word_end && !hold_load) begin
         ovf_reg <= 1'b1;
      end
   end

   assign ovf_o = ovf_reg;
`else
   assign ovf_o = 1'b0;
`endif

   assign rx.rx_data  = hold_data_reg;
   assign rx.rx_valid = hold_valid_reg;
   assign busy_o      = (state_reg != ST_IDLE);
   assign done_o      = done_reg;
   assign bit_cnt_o   = bit_cnt_reg;
endmodule

// File: tb/tb_qspi_rx_shifter.sv
// Bench for qspi_rx_shifter: directed cases plus random transfers, every cycle compared
// against a transfer-level reference model that assembles words from the list of received beats.
module tb_qspi_rx_shifter;
   localparam int DW  = 32;
   localparam int CW  = $clog2(DW + 1);
   localparam int WCW = 8;
`ifdef QSPI_RX_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           start_i;
   logic           abort_i;
   logic [1:0]     mode_i;
   logic           msb_first_i;
   logic [CW-1:0]  rlen_i;
   logic [WCW-1:0] rwords_i;
   logic           sample_i;
   logic [3:0]     sdi_i;
   logic           busy_o;
   logic           done_o;
   logic [CW-1:0]  bit_cnt_o;
   logic           ovf_o;

   qspi_rx_shifter_if #(.DW(DW)) rx_if ();

   qspi_rx_shifter #(.DW(DW), .CW(CW), .WCW(WCW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .mode_i      (mode_i),
      .msb_first_i (msb_first_i),
      .rlen_i      (rlen_i),
      .rwords_i    (rwords_i),
      .sample_i    (sample_i),
      .sdi_i       (sdi_i),
      .rx          (rx_if),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .bit_cnt_o   (bit_cnt_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
   endtask

   // Reference model state, tracked per transfer rather than per register.
   logic          m_busy, m_msb, m_hv, m_ovf, m_done;
   logic [1:0]    m_mode;
   int            m_rlen, m_words, m_bits;
   logic [DW-1:0] m_hd;
   int            beats[$];
   logic [3:0]    pat[$];
   logic [DW-1:0] deliv_q[$];

   function automatic int lanes_of(input logic [1:0] mode);
      return (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
   endfunction

   function automatic int eff_len(input logic [1:0] mode, input int rlen);
      int r = (rlen > DW) ? DW : rlen;
      return r - (r % lanes_of(mode));
   endfunction

   // MSB-first: each beat is appended below the earlier ones. LSB-first: beat k sits at bit k*L.
   function automatic logic [DW-1:0] assemble(input int q[$], input int lanes, input logic msb);
      logic [DW-1:0] w = '0;
      int pos = 0;
      foreach (q[i]) begin
         if (msb) w = (w << lanes) | DW'(q[i]);
         else begin
            w   = w | (DW'(q[i]) << pos);
            pos = pos + lanes;
         end
      end
      return w;
   endfunction

   task automatic step();
      logic          acc;
      logic          loaded;
      int            lanes;
      logic [3:0]    lv;
      m_done = 1'b0;
      if (rst_i) begin
         m_busy = 1'b0; m_hv = 1'b0; m_hd = '0; m_ovf = 1'b0; m_bits = 0;
         m_words = 0; m_rlen = 0; m_mode = 2'b00; m_msb = 1'b0;
         beats.delete();
      end else begin
         acc    = m_hv && rx_if.rx_ready;
         loaded = 1'b0;
         if (acc) deliv_q.push_back(rx_if.rx_data);
         if (!m_busy) begin
            if (start_i && rwords_i != '0 && eff_len(mode_i, int'(rlen_i)) != 0) begin
               m_busy  = 1'b1;
               m_mode  = mode_i;
               m_msb   = msb_first_i;
               m_rlen  = eff_len(mode_i, int'(rlen_i));
               m_words = int'(rwords_i);
               m_bits  = 0;
               beats.delete();
               if (OVF_EN) m_ovf = 1'b0;
            end
         end else if (abort_i) begin
            m_busy = 1'b0; m_bits = 0; m_done = 1'b1;
            beats.delete();
         end else if (sample_i) begin
            lanes = lanes_of(m_mode);
            lv = (lanes == 1) ? {3'b000, sdi_i[1]} : (lanes == 2) ? {2'b00, sdi_i[1:0]} : sdi_i;
            beats.push_back(int'(lv));
            m_bits = m_bits + lanes;
            if (m_bits == m_rlen) begin
               if (!m_hv || rx_if.rx_ready) begin
                  m_hd = assemble(beats, lanes, m_msb);
                  m_hv = 1'b1;
                  loaded = 1'b1;
               end else if (OVF_EN) begin
                  m_ovf = 1'b1;
               end
               m_bits  = 0;
               m_words = m_words - 1;
               beats.delete();
               if (m_words == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end
         if (acc && !loaded) m_hv = 1'b0;
      end
      @(posedge clk_i);
      #1;
      check("valid", rx_if.rx_valid, m_hv);
      if (m_hv) check("data", rx_if.rx_data, m_hd);
      check("busy", busy_o, m_busy);
      check("done", done_o, m_done);
      check("bit_cnt", bit_cnt_o, 64'(m_bits));
      check("ovf", ovf_o, m_ovf);
   endtask

   // rdy: 0 never ready, 1 always, 2 random, 3 ready only on the beat that ends the last word.
   task automatic set_ready(input int rdy);
      case (rdy)
         0: rx_if.rx_ready = 1'b0;
         1: rx_if.rx_ready = 1'b1;
         2: rx_if.rx_ready = 1'($urandom_range(0, 1));
         default: rx_if.rx_ready = sample_i && !abort_i && m_busy && (m_words == 1) &&
                                   (m_bits + lanes_of(m_mode) == m_rlen);
      endcase
   endtask

   task automatic run_xfer(input logic [1:0] mode, input logic msb, input int rlen, input int words,
                           input int gap, input int rdy, input int abort_at);
      int cyc = 0;
      int nb  = 0;
      start_i = 1'b1; mode_i = mode; msb_first_i = msb;
      rlen_i = CW'(rlen); rwords_i = WCW'(words);
      sample_i = 1'b0; abort_i = 1'b0;
      set_ready(rdy);
      step();
      start_i = 1'b0; mode_i = 2'($urandom); msb_first_i = 1'($urandom);
      rlen_i = CW'($urandom_range(0, DW)); rwords_i = WCW'($urandom);
      while (m_busy && cyc < 4000) begin
         abort_i  = (abort_at >= 0) && (nb == abort_at);
         sample_i = (gap < 0) ? 1'($urandom_range(0, 1)) : ((cyc % (gap + 1)) == 0);
         sdi_i    = (sample_i && pat.size() > 0) ? pat.pop_front() : 4'($urandom);
         if (sample_i && !abort_i) nb++;
         set_ready(rdy);
         step();
         cyc++;
      end
      abort_i  = 1'b0;
      sample_i = 1'b0;
      check("xfer_end_busy", busy_o, 1'b0);
      $display("xfer mode=%0d msb=%0d rlen=%0d words=%0d beats=%0d cycles=%0d",
               mode, msb, rlen, words, nb, cyc);
   endtask

   task automatic drain();
      sample_i = 1'b0;
      rx_if.rx_ready = 1'b1;
      repeat (2) step();
      rx_if.rx_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'b00; msb_first_i = 1'b0;
      rlen_i = '0; rwords_i = '0; sample_i = 1'b0; sdi_i = 4'h0; rx_if.rx_ready = 1'b0;
      repeat (2) step();
      rst_i = 1'b0;
      step();
      check("rst_data", rx_if.rx_data, '0);
      check("rst_cnt", bit_cnt_o, '0);

      // Quad MSB, 32 bits.
      for (int i = 1; i <= 8; i++) pat.push_back(4'(i));
      run_xfer(2'b10, 1'b1, 32, 1, 0, 0, -1);
      check("qmsb_data", rx_if.rx_data, 32'h12345678);
      check("qmsb_valid", rx_if.rx_valid, 1'b1);
      check("qmsb_done", done_o, 1'b1);
      drain();

      // Quad LSB, same nibbles.
      for (int i = 1; i <= 8; i++) pat.push_back(4'(i));
      run_xfer(2'b10, 1'b0, 32, 1, 0, 0, -1);
      check("qlsb_data", rx_if.rx_data, 32'h87654321);
      drain();

      // Single LSB, 8 bits, first bit 1.
      pat.push_back(4'b0010);
      for (int i = 0; i < 7; i++) pat.push_back(4'b0000);
      run_xfer(2'b00, 1'b0, 8, 1, 0, 0, -1);
      check("slsb_data", rx_if.rx_data, 32'h00000001);
      drain();

      // Dual MSB, 16 bits, strobe every other cycle.
      for (int i = 0; i < 8; i++) pat.push_back((i % 2 == 0) ? 4'h3 : 4'h0);
      run_xfer(2'b01, 1'b1, 16, 1, 1, 0, -1);
      check("dmsb_data", rx_if.rx_data, 32'h0000CCCC);
      drain();

      // Back-to-back handoff: ready only on the edge that completes word 2.
      deliv_q.delete();
      pat.push_back(4'h5); pat.push_back(4'hA); pat.push_back(4'hC); pat.push_back(4'h3);
      run_xfer(2'b10, 1'b1, 8, 2, 0, 3, -1);
      check("b2b_valid", rx_if.rx_valid, 1'b1);
      check("b2b_data2", rx_if.rx_data, 32'h000000C3);
      drain();
      check("b2b_count", 64'(deliv_q.size()), 64'd2);
      if (deliv_q.size() == 2) begin
         check("b2b_word1", deliv_q[0], 32'h0000005A);
         check("b2b_word2", deliv_q[1], 32'h000000C3);
      end

      // Overrun: three words, consumer never ready.
      pat.push_back(4'hA); pat.push_back(4'h1); pat.push_back(4'hB);
      pat.push_back(4'h2); pat.push_back(4'hC); pat.push_back(4'h3);
      run_xfer(2'b10, 1'b1, 8, 3, 0, 0, -1);
      check("ovr_data", rx_if.rx_data, 32'h000000A1);
      check("ovr_flag", ovf_o, OVF_EN);

      // Reset in the middle of a word, with a word still held.
      start_i = 1'b1; mode_i = 2'b10; msb_first_i = 1'b1; rlen_i = CW'(32); rwords_i = WCW'(1);
      step();
      start_i = 1'b0; sample_i = 1'b1;
      sdi_i = 4'h9; step();
      sdi_i = 4'h6; step();
      rst_i = 1'b1; sample_i = 1'b0;
      step();
      rst_i = 1'b0;
      check("mrst_valid", rx_if.rx_valid, 1'b0);
      check("mrst_data", rx_if.rx_data, '0);
      check("mrst_busy", busy_o, 1'b0);
      check("mrst_cnt", bit_cnt_o, '0);
      check("mrst_ovf", ovf_o, 1'b0);

      // Abort after three quad beats.
      run_xfer(2'b10, 1'b1, 32, 1, 0, 1, 3);
      check("abort_done", done_o, 1'b1);
      check("abort_valid", rx_if.rx_valid, 1'b0);
      step();
      check("abort_done_clr", done_o, 1'b0);

      // Ignored starts: zero words, and a length that truncates to zero.
      run_xfer(2'b10, 1'b1, 8, 0, 0, 1, -1);
      check("ign_words_done", done_o, 1'b0);
      run_xfer(2'b01, 1'b1, 1, 1, 0, 1, -1);
      check("ign_len_done", done_o, 1'b0);

      // Random transfers; the holding register is left full at times to provoke overruns.
      for (int t = 0; t < 40; t++) begin
         run_xfer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, DW),
                  $urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 0 : -1,
                  $urandom_range(0, 2),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1);
         if ($urandom_range(0, 2) != 0) drain();
         else step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
